// File: rtl/vote_report_tx.sv
// vote_report_tx: snapshots four vote counts and sends them as a framed 8N1 UART packet
module vote_report_tx #(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode,
  input  logic       report_req,
  input  logic [7:0] cand1_vote,
  input  logic [7:0] cand2_vote,
  input  logic [7:0] cand3_vote,
  input  logic [7:0] cand4_vote,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [1:0] leader,
  output logic       tie
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_q, bit_d;
  logic [2:0]      byte_q, byte_d;
  logic [3:0][7:0] snap_q, snap_d;
  logic [1:0]      leader_q, leader_d;
  logic            tie_q, tie_d;
  logic            done_q, done_d;
  logic [3:0][7:0] votes;
  logic [1:0]      lead_c;
  logic            tie_c;
  logic [7:0]      best;
  logic [2:0]      n_best;
  logic [9:0]      sum;
  logic [7:0]      cur_byte;
  logic            tick;

  assign votes    = {cand4_vote, cand3_vote, cand2_vote, cand1_vote};
  assign sum      = 10'(snap_q[0]) + 10'(snap_q[1]) + 10'(snap_q[2]) + 10'(snap_q[3]);
  assign cur_byte = byte_q == 3'd0 ? HEADER : byte_q == 3'd5 ? sum[7:0] : snap_q[2'(byte_q - 3'd1)];
  assign tick     = timer_q == TW'(CLKS_PER_BIT - 1);
  assign tx       = state_q == START ? 1'b0 : state_q == DATA ? cur_byte[bit_q] : 1'b1;
  assign busy     = state_q != IDLE;
  assign done     = done_q;
  assign leader   = leader_q;
  assign tie      = tie_q;

  // leader is the first strict maximum, so equal counts resolve to the lowest index
  always_comb begin
    best   = votes[0];
    lead_c = 2'd0;
    n_best = 3'd0;
    for (int i = 1; i < 4; i++)
      if (votes[i] > best) begin
        best   = votes[i];
        lead_c = 2'(i);
      end
    for (int i = 0; i < 4; i++)
      n_best = n_best + 3'(votes[i] == best);
    tie_c = n_best > 3'd1;
  end

  // framing FSM: bit timer paces START, eight DATA bits and STOP for each of six bytes
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    snap_d   = snap_q;
    leader_d = leader_q;
    tie_d    = tie_q;
    done_d   = 1'b0;
    if (state_q == IDLE) begin
      if (report_req && mode) begin
        state_d  = START;
        timer_d  = '0;
        bit_d    = '0;
        byte_d   = '0;
        snap_d   = votes;
        leader_d = lead_c;
        tie_d    = tie_c;
      end
    end else begin
      timer_d = tick ? '0 : timer_q + 1'b1;
      if (tick)
        case (state_q)
          START: begin
            state_d = DATA;
            bit_d   = '0;
          end
          DATA: begin
            state_d = bit_q == 3'd7 ? STOP : DATA;
            bit_d   = bit_q + 3'd1;
          end
          default: begin
            state_d = byte_q == 3'd5 ? IDLE : START;
            byte_d  = byte_q + 3'd1;
            done_d  = byte_q == 3'd5;
          end
        endcase
    end
  end

  // state registers; reset abandons any packet and clears the reported result
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      snap_q   <= '0;
      leader_q <= '0;
      tie_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      snap_q   <= snap_d;
      leader_q <= leader_d;
      tie_q    <= tie_d;
      done_q   <= done_d;
    end
  end
endmodule

// File: tb/tb_vote_report_tx.sv
// tb_vote_report_tx: directed checks of packet contents, timing, isolation and reset
module tb_vote_report_tx;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mode = 1'b0;
  logic       report_req = 1'b0;
  logic [7:0] cand1_vote = '0, cand2_vote = '0, cand3_vote = '0, cand4_vote = '0;
  logic       tx, busy, done, tie;
  logic [1:0] leader;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  vote_report_tx #(.CLKS_PER_BIT(4), .HEADER(8'hA5)) dut (
    .clock(clock), .reset(reset), .mode(mode), .report_req(report_req),
    .cand1_vote(cand1_vote), .cand2_vote(cand2_vote), .cand3_vote(cand3_vote), .cand4_vote(cand4_vote),
    .tx(tx), .busy(busy), .done(done), .leader(leader), .tie(tie)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_votes(input logic [7:0] a, b, c, d);
    cand1_vote = a; cand2_vote = b; cand3_vote = c; cand4_vote = d;
  endtask

  task automatic pulse_req();
    report_req = 1'b1;
    @(negedge clock);
    report_req = 1'b0;
  endtask

  task automatic idle_check(input string tag, input int n);
    logic bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
      @(negedge clock);
    end
    chk(tag, {31'd0, bad}, 32'd0);
  endtask

  task automatic check_packet(input string tag, input logic [47:0] exp, input logic [1:0] exp_lead, input logic exp_tie);
    logic rec [240];
    logic frame_bad = 1'b0;
    logic busy_bad = 1'b0;
    logic early_done = 1'b0;
    logic [7:0] got;
    int n = 0;
    while (tx !== 1'b0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_latency"}, n, 0);
    for (int i = 0; i < 240; i++) begin
      rec[i] = tx;
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (done !== 1'b0) early_done = 1'b1;
      @(negedge clock);
    end
    for (int j = 0; j < 6; j++) begin
      if (rec[j*40+2] !== 1'b0 || rec[j*40+38] !== 1'b1) frame_bad = 1'b1;
      for (int b = 0; b < 8; b++) got[b] = rec[(j*10+1+b)*4+2];
      chk($sformatf("%s_byte%0d", tag, j), {24'd0, got}, {24'd0, exp[47-8*j -: 8]});
    end
    chk({tag, "_framing"}, {31'd0, frame_bad}, 32'd0);
    chk({tag, "_busy_during"}, {31'd0, busy_bad}, 32'd0);
    chk({tag, "_no_early_done"}, {31'd0, early_done}, 32'd0);
    chk({tag, "_done_at_240"}, {30'd0, done, busy}, {30'd0, 2'b10});
    chk({tag, "_leader"}, {30'd0, leader}, {30'd0, exp_lead});
    chk({tag, "_tie"}, {31'd0, tie}, {31'd0, exp_tie});
  endtask

  initial begin
    int d0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("reset_state", {27'd0, tx, busy, done, leader, tie}, {27'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0});
    idle_check("idle20", 20);

    mode = 1'b1;
    set_votes(8'd3, 8'd5, 8'd0, 8'd255);
    pulse_req();
    check_packet("pkt1", 48'hA5_03_05_00_FF_07, 2'd3, 1'b0);
    @(negedge clock);

    mode = 1'b0;
    set_votes(8'd5, 8'd5, 8'd2, 8'd1);
    pulse_req();
    idle_check("mode0_ignored", 20);
    mode = 1'b1;
    pulse_req();
    check_packet("pkt2", 48'hA5_05_05_02_01_0D, 2'd0, 1'b1);
    @(negedge clock);

    set_votes(8'd1, 8'd2, 8'd3, 8'd4);
    pulse_req();
    d0 = done_cnt;
    fork
      check_packet("pkt3", 48'hA5_01_02_03_04_0A, 2'd3, 1'b0);
      begin
        repeat (60) @(negedge clock);
        set_votes(8'd9, 8'd9, 8'd9, 8'd9);
        mode = 1'b0;
        pulse_req();
        repeat (40) @(negedge clock);
        mode = 1'b1;
        pulse_req();
      end
    join
    @(negedge clock);
    idle_check("no_second_pkt", 300);
    chk("single_done", done_cnt - d0, 1);

    set_votes(8'd10, 8'd20, 8'd30, 8'd40);
    pulse_req();
    repeat (130) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_reset", {27'd0, tx, busy, done, leader, tie}, {27'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0});
    reset = 1'b0;
    idle_check("after_reset_idle", 10);

    set_votes(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    pulse_req();
    check_packet("pkt4", 48'hA5_FF_FF_FF_FF_FC, 2'd0, 1'b1);
    pulse_req();
    check_packet("pkt5", 48'hA5_FF_FF_FF_FF_FC, 2'd0, 1'b1);
    @(negedge clock);
    chk("final_idle", {30'd0, busy, done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
